multicycle_controller: RTL
==========================

# multicycle_controller

Moore-style control FSM for the multicycle MIPS datapath, successor to the single-cycle decoder/controller. It sequences each instruction through fetch, decode, execute, memory and writeback states, drives the shared-memory, IR, PC and register-file enables, and holds in memory states until a memory-ready handshake completes. Parametrised ALU-control width and optional `bne` support; detects illegal opcodes and illegal R-type functs.

## Interface
- `ALUCTRL_W`, 3, ALU control width (≥3); bits above [2:0] driven 0
- `ENABLE_BNE`, 1, 1 = decode `bne` (000101); 0 = treat it as illegal
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; forces FETCH and clears `illegal_op`
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes access this cycle
- `IorD`, `MemWrite`, `IRWrite`, `RegDst`, `MemToReg`, `RegWrite`, `ALUSrcA`  out  1 each
- `ALUSrcB`  out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
- `PCSrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `PCEn`  out  1  PC register enable
- `alucontrol`  out  ALUCTRL_W  ALU op
- `state`  out  4  current state (debug)
- `illegal_op`  out  1  sticky illegal opcode/funct flag

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 unreachable; if entered, next state FETCH.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp add, PCSrc=00; IRWrite=PCWrite=mem_ready. Stays until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp add. Next: lw/sw (100011/101011) → MEMADR; R-type (000000) → EXECUTE; beq (000100) and bne if enabled → BRANCH; addi (001000) → ADDIEX; j (000010) → JUMP; else set `illegal_op`, → FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: IorD=1; hold until mem_ready, then MEMWB. MEMWB: RegDst=0, MemToReg=1, RegWrite=1 → FETCH.
- MEMWR: IorD=1, MemWrite=1 held every cycle in state; exit to FETCH on mem_ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp funct → ALUWB. ALUWB: RegDst=1, MemToReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01; Branch asserted; taken = zero (beq) or ~zero (bne) → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add → ADDIWB: RegDst=0, MemToReg=0, RegWrite=1 → FETCH.
- JUMP: PCSrc=10, PCWrite=1 → FETCH.
- PCEn = PCWrite | (Branch & taken) (combinational).
- All unlisted controls 0 in each state. Opcode/funct sampled only in DECODE/MEMADR/EXECUTE/BRANCH (IR stable there).
- alucontrol: ALUOp add → 010, sub → 110; funct mode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; other funct → 010 and set `illegal_op` on the EXECUTE→ALUWB transition (writeback still occurs).

## Timing
- Reset (async): state=0, `illegal_op`=0; outputs immediately reflect FETCH (ALUSrcB=01, all write enables 0 unless mem_ready=1).
- Zero-wait latencies (cycles incl. fetch): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- IRWrite/PCWrite in FETCH assert only in the mem_ready=1 cycle; exactly one PC increment per instruction.
- Reset mid-instruction aborts it; no write enable asserts after reset edge.
- `illegal_op` stays 1 until reset.

## Test plan
- Reset asserted mid-MEMWR (MemWrite=1) → state=0, MemWrite=0 same cycle, `illegal_op`=0.
- lw (100011), mem_ready=1 always → states 0,1,2,3,4,0; RegWrite=1 & MemToReg=1 only in state 4.
- sw with mem_ready low 3 cycles in MEMWR → MemWrite=1 for 4 cycles, then FETCH.
- beq zero=1 → PCEn=1, PCSrc=01 in state 8; bne zero=1 with ENABLE_BNE=1 → PCEn=0; ENABLE_BNE=0 → `illegal_op`=1, back to FETCH after DECODE.
- R-type funct 101010 → alucontrol=111 in EXECUTE; funct 000111 → alucontrol=010, `illegal_op`=1.
- FETCH with mem_ready=0 for 5 cycles → IRWrite=PCWrite=0 throughout, state stays 0; rises to 1 on ready.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and holds memory states until mem_ready.
module multicycle_controller #(
  parameter int ALUCTRL_W  = 3,
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemToReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [3:0]           state,
  output logic                 illegal_op
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  EXECUTE = 4'd6, ALUWB  = 4'd7,
    BRANCH  = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     st;
  logic       is_lw, is_sw, is_rtype, is_branch, is_addi, is_j;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic [2:0] alu3;
  logic       pc_write, branch, taken;

  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_branch = (opcode == OP_BEQ) || (ENABLE_BNE && (opcode == OP_BNE));
  assign is_addi   = (opcode == OP_ADDI);
  assign is_j      = (opcode == OP_J);

  // R-type funct to ALU op; unknown functs fall back to add and are flagged
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State register and sticky illegal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      case (st)
        FETCH:   if (mem_ready) st <= DECODE;
        DECODE: begin
          if (is_lw || is_sw)  st <= MEMADR;
          else if (is_rtype)   st <= EXECUTE;
          else if (is_branch)  st <= BRANCH;
          else if (is_addi)    st <= ADDIEX;
          else if (is_j)       st <= JUMP;
          else begin
            illegal_op <= 1'b1;
            st         <= FETCH;
          end
        end
        MEMADR:  st <= is_lw ? MEMRD : (is_sw ? MEMWR : FETCH);
        MEMRD:   if (mem_ready) st <= MEMWB;
        MEMWR:   if (mem_ready) st <= FETCH;
        EXECUTE: begin
          if (!funct_ok) illegal_op <= 1'b1;
          st <= ALUWB;
        end
        ADDIEX:  st <= ADDIWB;
        default: st <= FETCH;
      endcase
    end
  end

  // Moore decode of the current state; only FETCH looks at mem_ready
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    alu3     = 3'b010;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (st)
      FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu3    = funct_alu;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu3    = 3'b110;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // bne only reaches BRANCH when enabled, so the opcode alone selects polarity
  assign taken      = (opcode == OP_BNE) ? ~zero : zero;
  assign PCEn       = pc_write | (branch & taken);
  assign alucontrol = ALUCTRL_W'(alu3);
  assign state      = st;

endmodule
